// File: rtl/rocketcpu_audio_pkg.sv
// Shared definitions for the audio parameter bus arbiter.
// FSM encodings and the slave address map.
package rocketcpu_audio_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT0  = 2'd1;
    localparam logic [1:0] ST_GNT1  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [31:0] AUDIO_REG_BASE = 32'h1000_0000;
    localparam logic [31:0] STATUS_BASE    = 32'h1001_0000;

endpackage

// File: rtl/rocketcpu_audio_arbiter_rr_arb2.sv
// Two-request round-robin picker.
// The requester that did not win last time takes a tie.
module rocketcpu_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    assign grant[0] = req[0] & (~req[1] | last_grant);
    assign grant[1] = req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/rocketcpu_audio_arbiter.sv
// Two-master round-robin Wishbone arbiter for the audio parameter slave.
// One transfer per grant, timeout error, post-transfer drain window.
module rocketcpu_audio_arbiter
    import rocketcpu_audio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int DRAIN_CYCLES   = 2
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    input  logic [3:0]  i_m0_sel,
    input  logic        i_m0_we,
    input  logic        i_m0_cyc,
    output logic [31:0] o_m0_rdt,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic [3:0]  i_m1_sel,
    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    output logic [31:0] o_m1_rdt,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    output logic [3:0]  o_s_sel,
    output logic        o_s_we,
    output logic        o_s_cyc,
    input  logic [31:0] i_s_rdt,
    input  logic        i_s_ack,
    output logic [1:0]  o_grant,
    output logic        o_busy
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0] DRN_LAST = 3'(DRAIN_CYCLES - 1);

    logic [1:0] state;
    logic       last_grant;
    logic [7:0] tmo_cnt;
    logic [2:0] drn_cnt;
    logic [1:0] pick;
    logic       own_cyc;
    logic       is_g1;

    rocketcpu_rr_arb2 u_rr (
        .req        ({i_m1_cyc, i_m0_cyc}),
        .last_grant (last_grant),
        .grant      (pick)
    );

    assign is_g1   = (state == ST_GNT1);
    assign own_cyc = is_g1 ? i_m1_cyc : i_m0_cyc;
    assign o_grant = {is_g1, state == ST_GNT0};
    assign o_busy  = (state != ST_IDLE);

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
            drn_cnt    <= '0;
            o_s_adr    <= '0;
            o_s_dat    <= '0;
            o_s_sel    <= '0;
            o_s_we     <= 1'b0;
            o_s_cyc    <= 1'b0;
            o_m0_rdt   <= '0;
            o_m1_rdt   <= '0;
            o_m0_ack   <= 1'b0;
            o_m1_ack   <= 1'b0;
            o_m0_err   <= 1'b0;
            o_m1_err   <= 1'b0;
        end else begin
            o_m0_ack <= 1'b0;
            o_m1_ack <= 1'b0;
            o_m0_err <= 1'b0;
            o_m1_err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (pick[0]) begin
                        state   <= ST_GNT0;
                        o_s_adr <= i_m0_adr;
                        o_s_dat <= i_m0_dat;
                        o_s_sel <= i_m0_sel;
                        o_s_we  <= i_m0_we;
                        o_s_cyc <= 1'b1;
                    end else if (pick[1]) begin
                        state   <= ST_GNT1;
                        o_s_adr <= i_m1_adr;
                        o_s_dat <= i_m1_dat;
                        o_s_sel <= i_m1_sel;
                        o_s_we  <= i_m1_we;
                        o_s_cyc <= 1'b1;
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    // ack beats abort and timeout when they coincide
                    if (i_s_ack) begin
                        if (is_g1) begin
                            o_m1_ack <= 1'b1;
                            o_m1_rdt <= i_s_rdt;
                        end else begin
                            o_m0_ack <= 1'b1;
                            o_m0_rdt <= i_s_rdt;
                        end
                        o_s_cyc    <= 1'b0;
                        last_grant <= is_g1;
                        state      <= ST_DRAIN;
                    end else if (!own_cyc) begin
                        o_s_cyc <= 1'b0;
                        state   <= ST_DRAIN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        o_m1_err   <= is_g1;
                        o_m0_err   <= ~is_g1;
                        o_s_cyc    <= 1'b0;
                        last_grant <= is_g1;
                        state      <= ST_DRAIN;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (drn_cnt == DRN_LAST) begin
                        drn_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        drn_cnt <= drn_cnt + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rocketcpu_audio_arbiter.sv
// Randomized and directed bench for the audio bus arbiter.
// A transaction-level model predicts every output each cycle.
module tb_rocketcpu_audio_arbiter;
    import rocketcpu_audio_pkg::*;

    localparam int TMO = 15;
    localparam int DRN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic [3:0]  m_sel [2];
    logic        m_we  [2];
    logic        m_cyc [2];
    logic [31:0] m_rdt [2];
    logic        m_ack [2];
    logic        m_err [2];
    logic [31:0] s_adr, s_dat, s_rdt;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_ack;
    logic [1:0]  grant;
    logic        busy;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rocketcpu_audio_arbiter #(.TIMEOUT_CYCLES(TMO), .DRAIN_CYCLES(DRN)) dut (
        .i_wb_clk(clk), .i_wb_rst_n(rst_n),
        .i_m0_adr(m_adr[0]), .i_m0_dat(m_dat[0]), .i_m0_sel(m_sel[0]),
        .i_m0_we(m_we[0]), .i_m0_cyc(m_cyc[0]),
        .o_m0_rdt(m_rdt[0]), .o_m0_ack(m_ack[0]), .o_m0_err(m_err[0]),
        .i_m1_adr(m_adr[1]), .i_m1_dat(m_dat[1]), .i_m1_sel(m_sel[1]),
        .i_m1_we(m_we[1]), .i_m1_cyc(m_cyc[1]),
        .o_m1_rdt(m_rdt[1]), .o_m1_ack(m_ack[1]), .o_m1_err(m_err[1]),
        .o_s_adr(s_adr), .o_s_dat(s_dat), .o_s_sel(s_sel),
        .o_s_we(s_we), .o_s_cyc(s_cyc),
        .i_s_rdt(s_rdt), .i_s_ack(s_ack),
        .o_grant(grant), .o_busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    endtask

    // Register slave: two-stage ack pipeline, trailing acks after cyc drops
    logic [31:0] mem [256];
    logic        p1, p2;
    logic        noack = 1'b0;
    logic [31:0] status = 32'h0;
    logic        mapped;

    assign mapped = (s_adr[31:16] == 16'h1000) || (s_adr[31:16] == 16'h1001);
    assign s_ack  = p2;
    always_comb begin
        s_rdt = mem[s_adr[9:2]];
        if (s_adr[31:16] == 16'h1001) s_rdt = status;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
        end else begin
            p1 <= s_cyc && mapped && !noack;
            p2 <= p1;
            if (p2 && s_cyc && s_we && s_adr[31:16] == 16'h1000)
                for (int b = 0; b < 4; b++)
                    if (s_sel[b]) mem[s_adr[9:2]][b*8 +: 8] <= s_dat[b*8 +: 8];
        end
    end

    // Behavioural model: owner/age/drain countdown, updated per clock
    int          own = -1, age = 0, dleft = 0, lastg = 1;
    logic        e_ack [2] = '{1'b0, 1'b0};
    logic        e_err [2] = '{1'b0, 1'b0};
    logic [31:0] e_rdt [2] = '{32'h0, 32'h0};
    logic        e_scyc = 1'b0, e_swe = 1'b0;
    logic [31:0] e_sadr = 32'h0, e_sdat = 32'h0;
    logic [3:0]  e_ssel = 4'h0;
    int          w;
    bit          done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own = -1; age = 0; dleft = 0; lastg = 1;
            e_ack = '{1'b0, 1'b0}; e_err = '{1'b0, 1'b0};
            e_rdt = '{32'h0, 32'h0};
            e_scyc = 1'b0; e_swe = 1'b0; e_sadr = '0; e_sdat = '0; e_ssel = '0;
        end else begin
            e_ack = '{1'b0, 1'b0};
            e_err = '{1'b0, 1'b0};
            done = 1'b0;
            if (dleft > 0) begin
                dleft--;
            end else if (own < 0) begin
                w = -1;
                if (m_cyc[0] && m_cyc[1]) w = 1 - lastg;
                else if (m_cyc[0]) w = 0;
                else if (m_cyc[1]) w = 1;
                if (w >= 0) begin
                    own = w; age = 0; e_scyc = 1'b1;
                    e_sadr = m_adr[w]; e_sdat = m_dat[w];
                    e_ssel = m_sel[w]; e_swe = m_we[w];
                end
            end else if (s_ack) begin
                e_ack[own] = 1'b1; e_rdt[own] = s_rdt; lastg = own; done = 1'b1;
            end else if (!m_cyc[own]) begin
                done = 1'b1;
            end else begin
                age++;
                if (age >= TMO) begin
                    e_err[own] = 1'b1; lastg = own; done = 1'b1;
                end
            end
            if (done) begin
                e_scyc = 1'b0; own = -1; dleft = DRN;
            end
        end
    end

    always @(negedge clk) begin
        chk("ack0", 32'(m_ack[0]), 32'(e_ack[0]));
        chk("ack1", 32'(m_ack[1]), 32'(e_ack[1]));
        chk("err0", 32'(m_err[0]), 32'(e_err[0]));
        chk("err1", 32'(m_err[1]), 32'(e_err[1]));
        chk("rdt0", m_rdt[0], e_rdt[0]);
        chk("rdt1", m_rdt[1], e_rdt[1]);
        chk("s_cyc", 32'(s_cyc), 32'(e_scyc));
        chk("grant", 32'(grant), (own == 0) ? 32'd1 : (own == 1) ? 32'd2 : 32'd0);
        chk("busy", 32'(busy), 32'((own >= 0) || (dleft > 0)));
        if (e_scyc || !rst_n) begin
            chk("s_adr", s_adr, e_sadr);
            chk("s_dat", s_dat, e_sdat);
            chk("s_sel", 32'(s_sel), 32'(e_ssel));
            chk("s_we", 32'(s_we), 32'(e_swe));
        end
    end

    int order [$];
    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_ack[0]) order.push_back(0);
            if (m_ack[1]) order.push_back(1);
        end
    end

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Call just after a posedge; holds cyc until ack/err or abort cycle
    task automatic xfer(input int m, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we, input int abort_at,
                        output logic [31:0] rdt, output int res);
        rdt = '0;
        res = 0;
        m_adr[m] = adr; m_dat[m] = dat; m_sel[m] = sel; m_we[m] = we; m_cyc[m] = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (m_ack[m]) begin res = 1; rdt = m_rdt[m]; break; end
            if (m_err[m]) begin res = 2; break; end
            if (abort_at > 0 && k + 1 >= abort_at) begin res = 3; break; end
        end
        if (res == 0) begin
            n_checks++;
            $display("FAIL xfer_wait m%0d actual=no_response required=ack_or_err", m);
        end
        @(posedge clk);
        #1;
        m_cyc[m] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_master(input int m, input int n);
        logic [31:0] adr, rd;
        int r, res;
        for (int i = 0; i < n; i++) begin
            idle($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if (r < 8) adr = AUDIO_REG_BASE + 32'($urandom_range(0, 15) * 4);
            else if (r == 8) adr = STATUS_BASE;
            else adr = 32'h2000_0000;
            xfer(m, adr, $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0, rd, res);
        end
    endtask

    logic [1:0]  gexp [8];
    logic [1:0]  grec [8];
    logic [31:0] rd0, rd1;
    int          res0, res1, ks, ke, ka1, nack, nerr;
    logic        b1, b2, sc3;

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0; m_we[m] = 1'b0; m_cyc[m] = 1'b0;
        end
        gexp = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10};
        do_reset();

        // reset state
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_adr", s_adr, 32'h0);

        // single write: slave cyc at cycle 1, ack at cycle 4, then readback
        ks = -1; ke = -1;
        fork
            xfer(0, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 0, rd0, res0);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (s_cyc && ks < 0) ks = k;
                if (m_ack[0] && ke < 0) ke = k;
            end
        join
        chk("t1_scyc_cycle", ks, 1);
        chk("t1_ack_cycle", ke, 4);
        idle(4);
        xfer(1, 32'h1000_0004, 32'h0, 4'hF, 1'b0, 0, rd1, res1);
        chk("t1_readback", rd1, 32'hDEAD_BEEF);

        // simultaneous requests straight after reset
        do_reset();
        ka1 = -1;
        fork
            xfer(0, 32'h1000_0008, 32'h0, 4'hF, 1'b0, 0, rd0, res0);
            xfer(1, 32'h1000_000C, 32'h0, 4'hF, 1'b0, 0, rd1, res1);
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (k < 8) grec[k] = grant;
                if (m_ack[1] && ka1 < 0) ka1 = k;
            end
        join
        for (int k = 0; k < 8; k++) chk($sformatf("t2_grant_c%0d", k), 32'(grec[k]), 32'(gexp[k]));
        chk("t2_m1_ack_cycle", ka1, 10);

        // continuous requests alternate strictly, m0 first after m1 won last
        order.delete();
        mon_en = 1'b1;
        fork
            repeat (3) xfer(0, AUDIO_REG_BASE + 32'h20, 32'h1111_0000, 4'hF, 1'b1, 0, rd0, res0);
            repeat (3) xfer(1, AUDIO_REG_BASE + 32'h24, 32'h2222_0000, 4'hF, 1'b1, 0, rd1, res1);
        join
        idle(4);
        mon_en = 1'b0;
        chk("t3_count", order.size(), 6);
        for (int i = 0; i < order.size() && i < 6; i++)
            chk($sformatf("t3_order%0d", i), order[i], i % 2);

        // slave never acks: err 15 cycles after slave cyc, then 2 drain cycles
        noack = 1'b1;
        ks = -1; ke = -1; nack = 0; b1 = 1'b0; b2 = 1'b1;
        fork
            xfer(1, AUDIO_REG_BASE, 32'h0, 4'hF, 1'b0, 0, rd1, res1);
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                if (s_cyc && ks < 0) ks = k;
                if (m_ack[1]) nack++;
                if (ke >= 0 && k == ke + 1) b1 = busy;
                if (ke >= 0 && k == ke + 2) b2 = busy;
                if (m_err[1] && ke < 0) ke = k;
            end
        join
        noack = 1'b0;
        chk("t4_err_delay", ke - ks, 15);
        chk("t4_result", res1, 2);
        chk("t4_no_ack", nack, 0);
        chk("t4_busy_drain", 32'(b1), 32'd1);
        chk("t4_busy_idle", 32'(b2), 32'd0);

        // m0 aborts one cycle after grant; late slave ack must be swallowed
        idle(2);
        nack = 0; nerr = 0; sc3 = 1'b1;
        fork
            xfer(0, AUDIO_REG_BASE + 32'h30, 32'h0, 4'hF, 1'b0, 2, rd0, res0);
            begin
                idle(1);
                xfer(1, AUDIO_REG_BASE + 32'h34, 32'hCAFE_F00D, 4'hF, 1'b1, 0, rd1, res1);
            end
            for (int k = 0; k < 25; k++) begin
                @(negedge clk);
                if (k == 3) sc3 = s_cyc;
                if (m_ack[0]) nack++;
                if (m_err[0]) nerr++;
            end
        join
        chk("t5_scyc_dropped", 32'(sc3), 32'd0);
        chk("t5_m0_no_ack", nack, 0);
        chk("t5_m0_no_err", nerr, 0);
        chk("t5_m1_done", res1, 1);

        // reset in the middle of a grant
        idle(2);
        status = 32'h5A5A_1234;
        m_adr[0] = AUDIO_REG_BASE; m_sel[0] = 4'hF; m_we[0] = 1'b0; m_cyc[0] = 1'b1;
        idle(2);
        chk("t6_in_grant", 32'(grant), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_scyc", 32'(s_cyc), 32'd0);
        chk("t6_rst_grant", 32'(grant), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_sadr", s_adr, 32'h0);
        m_cyc[0] = 1'b0;
        do_reset();
        xfer(0, STATUS_BASE, 32'h0, 4'hF, 1'b0, 0, rd0, res0);
        chk("t6_status_ack", res0, 1);
        chk("t6_status_rdt", rd0, status);

        // random traffic from both masters with aborts and unmapped accesses
        idle(3);
        for (int round = 0; round < 3; round++) begin
            status = $urandom;
            fork
                rand_master(0, 20);
                rand_master(1, 20);
            join
            idle(4);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
